// File: rtl/elink_rx_dispatcher.sv
// Elink receive parser: acquires comma lock, parses SOP/channel/payload/EOP frames and queues
// channel-tagged bytes in a FIFO. Define ELINK_RX_ERRCNT_EN to add the saturating err_cnt output.
module elink_rx_dispatcher #(
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned LOCK_COMMAS = 4,
    parameter int unsigned MAX_LEN     = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  data_rec_in,
    input  logic        data_rec_vld,
    input  logic [7:0]  Kchar_comma,
    input  logic [7:0]  Kchar_sop,
    input  logic [7:0]  Kchar_eop,
    output logic [7:0]  rx_data_out,
    output logic [1:0]  rx_chan_out,
    output logic        rx_sop_out,
    output logic        rx_eop_out,
    output logic        rx_err_out,
    output logic        rx_valid_out,
    input  logic        rx_ready_in,
    output logic        locked,
`ifdef ELINK_RX_ERRCNT_EN
    output logic [15:0] err_cnt,
`endif
    output logic        frame_err
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned LW = $clog2(MAX_LEN + 1);
    localparam int unsigned KW = $clog2(LOCK_COMMAS + 1);

    typedef enum logic [2:0] {StUnlocked, StIdle, StSel, StPayload, StDrop} state_e;

    state_e        state_q, state_d;
    logic [KW-1:0] comma_q, comma_d;
    logic [1:0]    chan_q, chan_d;
    logic [7:0]    hold_q, hold_d;
    logic          hold_vld_q, hold_vld_d;
    logic          sent_q, sent_d;
    logic [LW-1:0] len_q, len_d;
    logic          ferr_q, ferr_d;

    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] cnt_q, avail;
    logic [12:0]   mem [FIFO_DEPTH];
    logic [12:0]   head;
    logic          pop;

    logic       push, do_push, push_sop, push_eop, push_err, trunc;
    logic [7:0] push_byte;

    logic [7:0] wbyte;
    logic       is_k, is_d, is_comma, is_sop, is_eop, bad_word;

    assign wbyte    = data_rec_in[7:0];
    assign is_k     = (data_rec_in[9:8] == 2'b11);
    assign is_d     = (data_rec_in[9:8] == 2'b00);
    assign is_comma = is_k && (wbyte == Kchar_comma);
    assign is_sop   = is_k && (wbyte == Kchar_sop);
    assign is_eop   = is_k && (wbyte == Kchar_eop);
    assign bad_word = (data_rec_in[9] ^ data_rec_in[8]) || (is_k && !is_comma && !is_sop && !is_eop);

    assign rx_valid_out = (cnt_q != '0);
    assign pop          = rx_valid_out && rx_ready_in;
    // A same-cycle pop frees an entry for this cycle's push.
    assign avail        = CW'(FIFO_DEPTH) - cnt_q + CW'(pop);
    assign head         = mem[rd_ptr_q];
    assign {rx_err_out, rx_eop_out, rx_sop_out, rx_chan_out, rx_data_out} =
        rx_valid_out ? head : '0;
    assign locked       = (state_q != StUnlocked);
    assign frame_err    = ferr_q;

    always_comb begin
        state_d    = state_q;
        comma_d    = comma_q;
        chan_d     = chan_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        sent_d     = sent_q;
        len_d      = len_q;
        ferr_d     = 1'b0;
        push       = 1'b0;
        push_byte  = hold_q;
        push_sop   = !sent_q;
        push_eop   = 1'b0;
        push_err   = 1'b0;
        trunc      = 1'b0;
        do_push    = 1'b0;
        if (data_rec_vld) begin
            if (bad_word) begin
                state_d = StUnlocked;
                comma_d = '0;
                ferr_d  = 1'b1;
                trunc   = (state_q == StPayload);
            end else begin
                unique case (state_q)
                    StUnlocked: begin
                        if (!is_comma) begin
                            comma_d = '0;
                        end else if (comma_q == KW'(LOCK_COMMAS - 1)) begin
                            comma_d = '0;
                            state_d = StIdle;
                        end else begin
                            comma_d = comma_q + 1'b1;
                        end
                    end
                    StIdle: if (is_sop) state_d = StSel;
                    StSel: begin
                        if (is_d && wbyte < 8'd3) begin
                            chan_d     = wbyte[1:0];
                            hold_vld_d = 1'b0;
                            sent_d     = 1'b0;
                            len_d      = '0;
                            state_d    = StPayload;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = StDrop;
                        end
                    end
                    StPayload: begin
                        if (is_d) begin
                            if (len_q == LW'(MAX_LEN)) begin
                                trunc   = 1'b1;
                                ferr_d  = 1'b1;
                                state_d = StDrop;
                            end else begin
                                len_d      = len_q + 1'b1;
                                hold_d     = wbyte;
                                hold_vld_d = 1'b1;
                                push       = hold_vld_q;
                            end
                        end else if (is_eop) begin
                            push     = hold_vld_q;
                            push_eop = 1'b1;
                            state_d  = StIdle;
                        end else if (is_sop) begin
                            trunc   = 1'b1;
                            ferr_d  = 1'b1;
                            state_d = StSel;
                        end
                    end
                    StDrop: begin
                        if (is_eop) state_d = StIdle;
                        else if (is_sop) state_d = StSel;
                    end
                    default: state_d = StUnlocked;
                endcase
            end
        end
        // Close an aborted frame; an empty hold after bytes left needs a bare marker entry.
        if (trunc) begin
            push_eop = 1'b1;
            push_err = 1'b1;
            if (hold_vld_q) begin
                push = 1'b1;
            end else if (sent_q) begin
                push      = 1'b1;
                push_byte = 8'h00;
                push_sop  = 1'b0;
            end
        end
        if (push) begin
            if (avail == '0) begin
                ferr_d = 1'b1;
                if (state_d == StPayload) state_d = StDrop;
            end else begin
                do_push = 1'b1;
                sent_d  = 1'b1;
                // Last free slot: close the frame here so it can never be left open.
                if (avail == CW'(1)) begin
                    push_eop = 1'b1;
                    push_err = 1'b1;
                    ferr_d   = 1'b1;
                    if (state_d == StPayload) state_d = StDrop;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StUnlocked;
            comma_q    <= '0;
            chan_q     <= '0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            sent_q     <= 1'b0;
            len_q      <= '0;
            ferr_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            comma_q    <= comma_d;
            chan_q     <= chan_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            sent_q     <= sent_d;
            len_q      <= len_d;
            ferr_q     <= ferr_d;
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_q + CW'(do_push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= {push_err, push_eop, push_sop, chan_q, push_byte};
    end

`ifdef ELINK_RX_ERRCNT_EN
    logic [15:0] err_cnt_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt_q <= '0;
        end else if (ferr_d && err_cnt_q != 16'hFFFF) begin
            err_cnt_q <= err_cnt_q + 1'b1;
        end
    end
    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_elink_rx_dispatcher.sv
// Self-checking bench for elink_rx_dispatcher: scoreboard of expected FIFO entries per frame.
module tb_elink_rx_dispatcher;
    localparam int unsigned DEPTH = 4;
    localparam logic [9:0] W_COMMA = 10'h3BC;
    localparam logic [9:0] W_SOP   = 10'h33C;
    localparam logic [9:0] W_EOP   = 10'h3DC;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [9:0] data_rec_in = '0;
    logic       data_rec_vld = 1'b0;
    logic [7:0] rx_data_out;
    logic [1:0] rx_chan_out;
    logic       rx_sop_out, rx_eop_out, rx_err_out, rx_valid_out;
    logic       rx_ready_in = 1'b1;
    logic       locked, frame_err;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          ferr_cnt = 0;
    logic [12:0] exp_q[$];
    logic [12:0] head;
    logic [15:0] all_out;

    assign head    = {rx_err_out, rx_eop_out, rx_sop_out, rx_chan_out, rx_data_out};
    assign all_out = {rx_valid_out, locked, frame_err, head};

    elink_rx_dispatcher #(
        .FIFO_DEPTH (DEPTH),
        .LOCK_COMMAS(4),
        .MAX_LEN    (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .data_rec_in (data_rec_in),
        .data_rec_vld(data_rec_vld),
        .Kchar_comma (8'hBC),
        .Kchar_sop   (8'h3C),
        .Kchar_eop   (8'hDC),
        .rx_data_out (rx_data_out),
        .rx_chan_out (rx_chan_out),
        .rx_sop_out  (rx_sop_out),
        .rx_eop_out  (rx_eop_out),
        .rx_err_out  (rx_err_out),
        .rx_valid_out(rx_valid_out),
        .rx_ready_in (rx_ready_in),
        .locked      (locked),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] ent(input logic err, input logic eop, input logic sop,
                                        input logic [1:0] ch, input logic [7:0] b);
        return {err, eop, sop, ch, b};
    endfunction

    task automatic monitor();
        logic [12:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (frame_err) ferr_cnt++;
                if (rx_valid_out && rx_ready_in) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL fifo_head: got unexpected entry %h, required none", head);
                    end else begin
                        e = exp_q.pop_front();
                        if (head !== e) begin
                            n_fail++;
                            $display("FAIL fifo_head: got %h, required %h", head, e);
                        end
                    end
                end
            end
        end
    endtask

    task automatic send(input logic [9:0] w);
        data_rec_in  = w;
        data_rec_vld = 1'b1;
        @(posedge clk);
        #1;
        data_rec_vld = 1'b0;
        data_rec_in  = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input string name);
        int k = 0;
        idle(2);
        while (exp_q.size() != 0 && k < 60) begin
            idle(1);
            k++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: %0d entries pending, required 0", name, exp_q.size());
        end
        n_cmp++;
        if (rx_valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_empty: rx_valid_out=%b, required 0", name, rx_valid_out);
        end
    endtask

    task automatic lock_link(input string name);
        repeat (4) send(W_COMMA);
        n_cmp++;
        if (locked !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_lock: locked=%b, required 1", name, locked);
        end
    endtask

    task automatic test_reset();
        n_cmp++;
        if (all_out !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_in: outputs=%h, required 0000", all_out);
        end
        idle(2);
        rst = 1'b1;
        idle(2);
        n_cmp++;
        if (all_out !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_out: outputs=%h, required 0000", all_out);
        end
    endtask

    task automatic test_lock_frame();
        int f0 = ferr_cnt;
        repeat (3) send(W_COMMA);
        n_cmp++;
        if (locked !== 1'b0) begin
            n_fail++;
            $display("FAIL lock_early: locked=%b after 3 commas, required 0", locked);
        end
        send(W_COMMA);
        n_cmp++;
        if (locked !== 1'b1) begin
            n_fail++;
            $display("FAIL lock_4th: locked=%b after 4 commas, required 1", locked);
        end
        send(W_COMMA);
        send(W_SOP);
        send(10'h001);
        send(10'h0AA);
        exp_q.push_back(ent(1'b0, 1'b0, 1'b1, 2'd1, 8'hAA));
        send(10'h055);
        exp_q.push_back(ent(1'b0, 1'b1, 1'b0, 2'd1, 8'h55));
        send(W_EOP);
        drain("lock_frame");
        n_cmp++;
        if (ferr_cnt - f0 !== 0) begin
            n_fail++;
            $display("FAIL lock_frame_ferr: pulses=%0d, required 0", ferr_cnt - f0);
        end
    endtask

    task automatic test_bad_channel();
        int f0 = ferr_cnt;
        send(W_SOP);
        send(10'h003);
        send(10'h011);
        send(W_EOP);
        drain("bad_chan");
        n_cmp++;
        if (ferr_cnt - f0 !== 1) begin
            n_fail++;
            $display("FAIL bad_chan_ferr: pulses=%0d, required 1", ferr_cnt - f0);
        end
        n_cmp++;
        if (locked !== 1'b1) begin
            n_fail++;
            $display("FAIL bad_chan_lock: locked=%b, required 1", locked);
        end
    endtask

    task automatic test_code_error();
        int f0 = ferr_cnt;
        send(W_SOP);
        send(10'h000);
        send(10'h011);
        exp_q.push_back(ent(1'b1, 1'b1, 1'b1, 2'd0, 8'h11));
        send(10'h100);
        n_cmp++;
        if (locked !== 1'b0) begin
            n_fail++;
            $display("FAIL code_err_lock: locked=%b, required 0", locked);
        end
        drain("code_err");
        n_cmp++;
        if (ferr_cnt - f0 !== 1) begin
            n_fail++;
            $display("FAIL code_err_ferr: pulses=%0d, required 1", ferr_cnt - f0);
        end
        lock_link("relock");
    endtask

    task automatic test_zero_len();
        int f0 = ferr_cnt;
        send(W_SOP);
        send(10'h002);
        send(W_EOP);
        idle(2);
        n_cmp++;
        if (rx_valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_len_push: rx_valid_out=%b, required 0", rx_valid_out);
        end
        send(W_SOP);
        send(10'h002);
        send(10'h0FF);
        send(W_COMMA);
        exp_q.push_back(ent(1'b0, 1'b1, 1'b1, 2'd2, 8'hFF));
        send(W_EOP);
        drain("zero_len");
        n_cmp++;
        if (ferr_cnt - f0 !== 0) begin
            n_fail++;
            $display("FAIL zero_len_ferr: pulses=%0d, required 0", ferr_cnt - f0);
        end
    endtask

    task automatic test_max_len();
        int f0 = ferr_cnt;
        logic [7:0] b;
        // Exactly MAX_LEN bytes: complete frame, no error.
        send(W_SOP);
        send(10'h001);
        for (int i = 0; i < 16; i++) begin
            b = 8'(i * 7 + 1);
            send({2'b00, b});
            exp_q.push_back(ent(1'b0, i == 15, i == 0, 2'd1, b));
        end
        send(W_EOP);
        drain("len16");
        n_cmp++;
        if (ferr_cnt - f0 !== 0) begin
            n_fail++;
            $display("FAIL len16_ferr: pulses=%0d, required 0", ferr_cnt - f0);
        end
        // One byte over: 16th byte closes with err, 17th discarded.
        f0 = ferr_cnt;
        send(W_SOP);
        send(10'h002);
        for (int i = 0; i < 17; i++) begin
            b = 8'(i * 5 + 3);
            send({2'b00, b});
            if (i < 16) exp_q.push_back(ent(i == 15, i == 15, i == 0, 2'd2, b));
        end
        send(W_EOP);
        drain("len17");
        n_cmp++;
        if (ferr_cnt - f0 !== 1) begin
            n_fail++;
            $display("FAIL len17_ferr: pulses=%0d, required 1", ferr_cnt - f0);
        end
    endtask

    task automatic test_sop_mid_frame();
        int f0 = ferr_cnt;
        send(W_SOP);
        send(10'h000);
        send(10'h010);
        send(10'h020);
        exp_q.push_back(ent(1'b0, 1'b0, 1'b1, 2'd0, 8'h10));
        send(W_SOP);
        exp_q.push_back(ent(1'b1, 1'b1, 1'b0, 2'd0, 8'h20));
        send(10'h001);
        send(10'h030);
        send(W_EOP);
        exp_q.push_back(ent(1'b0, 1'b1, 1'b1, 2'd1, 8'h30));
        drain("sop_mid");
        n_cmp++;
        if (ferr_cnt - f0 !== 1) begin
            n_fail++;
            $display("FAIL sop_mid_ferr: pulses=%0d, required 1", ferr_cnt - f0);
        end
    endtask

    task automatic test_overflow();
        int f0 = ferr_cnt;
        logic [7:0] b;
        rx_ready_in = 1'b0;
        send(W_SOP);
        send(10'h002);
        for (int i = 0; i < 6; i++) begin
            b = 8'h40 + 8'(i);
            send({2'b00, b});
        end
        send(W_EOP);
        for (int i = 0; i < 4; i++) begin
            b = 8'h40 + 8'(i);
            exp_q.push_back(ent(i == 3, i == 3, i == 0, 2'd2, b));
        end
        idle(3);
        n_cmp++;
        if (rx_valid_out !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_held: rx_valid_out=%b, required 1", rx_valid_out);
        end
        n_cmp++;
        if (ferr_cnt - f0 !== 1) begin
            n_fail++;
            $display("FAIL ovf_ferr: pulses=%0d, required 1", ferr_cnt - f0);
        end
        rx_ready_in = 1'b1;
        drain("overflow");
    endtask

    task automatic test_back_to_back();
        int f0 = ferr_cnt;
        int len;
        logic [1:0] ch;
        logic [7:0] b;
        for (int f = 0; f < 6; f++) begin
            len = int'($urandom_range(1, 6));
            ch  = 2'($urandom_range(0, 2));
            send(W_SOP);
            send({8'h00, ch});
            for (int i = 0; i < len; i++) begin
                b = 8'($urandom);
                send({2'b00, b});
                exp_q.push_back(ent(1'b0, i == len - 1, i == 0, ch, b));
                if ($urandom_range(0, 3) == 0) send(W_COMMA);
            end
            send(W_EOP);
        end
        drain("b2b");
        n_cmp++;
        if (ferr_cnt - f0 !== 0) begin
            n_fail++;
            $display("FAIL b2b_ferr: pulses=%0d, required 0", ferr_cnt - f0);
        end
    endtask

    task automatic test_reset_mid();
        rx_ready_in = 1'b0;
        send(W_SOP);
        send(10'h001);
        send(10'h0A1);
        send(10'h0A2);
        idle(1);
        n_cmp++;
        if (rx_valid_out !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_pre: rx_valid_out=%b, required 1", rx_valid_out);
        end
        #2;
        rst = 1'b0;
        #1;
        n_cmp++;
        if (all_out !== 16'h0) begin
            n_fail++;
            $display("FAIL rst_mid_async: outputs=%h, required 0000", all_out);
        end
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        rx_ready_in = 1'b1;
        idle(2);
        n_cmp++;
        if (all_out !== 16'h0) begin
            n_fail++;
            $display("FAIL rst_mid_after: outputs=%h, required 0000", all_out);
        end
        lock_link("rst_relock");
        send(W_SOP);
        send(10'h000);
        send(10'h077);
        exp_q.push_back(ent(1'b0, 1'b1, 1'b1, 2'd0, 8'h77));
        send(W_EOP);
        drain("rst_mid");
    endtask

    initial begin
        fork
            monitor();
        join_none
        #1;
        test_reset();
        test_lock_frame();
        test_bad_channel();
        test_code_error();
        test_zero_len();
        test_max_len();
        test_sop_mid_frame();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
